// File: rtl/plic_src_conditioner.sv
// -----------------------------------------------------------------------------
// plic_src_conditioner
//
// Conditions each raw interrupt line before it reaches the PLIC gateways. Every
// line is handled independently:
//   1. polarity is normalised so an active input becomes 1,
//   2. the line is synchronised into the PCLK domain,
//   3. a new level is accepted only after it has been stable for FILTER_CYCLES
//      consecutive cycles, unless the line is bypassed,
//   4. a one-cycle pulse marks each accepted 0->1 transition,
//   5. a sticky flag records every excursion that the filter rejected.
//
// Parameters
//   SOURCES        number of interrupt lines (match the PLIC)
//   SYNC_STAGES    synchronizer depth, >= 2
//   FILTER_BITS    width of each filter counter
//   FILTER_CYCLES  stable cycles needed to accept a level, 1 .. 2^FILTER_BITS-1
//   POLARITY       per-line active level, 1 = active-high, 0 = active-low
//
// Ports
//   PCLK        system clock
//   PRESETn     asynchronous active-low reset
//   src_async   raw interrupt lines, asynchronous to PCLK
//   bypass      per-line filter bypass, quasi-static
//   glitch_clr  per-line clear of the glitch flag, sampled every cycle
//   src         conditioned active-high level to the PLIC
//   src_rise    one-cycle pulse, high in the cycle after src rises
//   glitch      sticky flag, a pulse on this line was rejected
// -----------------------------------------------------------------------------
module plic_src_conditioner #(
  parameter int unsigned         SOURCES       = 5,
  parameter int unsigned         SYNC_STAGES   = 2,
  parameter int unsigned         FILTER_BITS   = 4,
  parameter int unsigned         FILTER_CYCLES = 4,
  parameter logic [SOURCES-1:0]  POLARITY      = {SOURCES{1'b1}}
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [SOURCES-1:0] src_async,
  input  logic [SOURCES-1:0] bypass,
  input  logic [SOURCES-1:0] glitch_clr,
  output logic [SOURCES-1:0] src,
  output logic [SOURCES-1:0] src_rise,
  output logic [SOURCES-1:0] glitch
);

  // Comparing against FILTER_CYCLES-1 is the same test as cnt+1 == FILTER_CYCLES
  // but stays inside FILTER_BITS, so no wider arithmetic is needed.
  localparam logic [FILTER_BITS-1:0] CNT_LAST = FILTER_BITS'(FILTER_CYCLES - 1);

  typedef struct packed {
    logic                   s;
    logic [FILTER_BITS-1:0] cnt;
    logic                   glitch_set;
  } filt_t;

  // Next state of one line's filter. A counter that is non-zero when the input
  // falls back to the stable level means an excursion was cut short: that is
  // the glitch condition. Bypass always follows the input and discards any
  // partial count without flagging it.
  function automatic filt_t filt_step(
    input logic                   v,
    input logic                   s,
    input logic                   byp,
    input logic [FILTER_BITS-1:0] cnt
  );
    filt_t r;
    r.s          = s;
    r.cnt        = '0;
    r.glitch_set = 1'b0;
    if (byp) begin
      r.s = v;
    end else if (v == s) begin
      r.glitch_set = (cnt != '0);
    end else if (cnt == CNT_LAST) begin
      r.s = v;
    end else begin
      r.cnt = cnt + 1'b1;
    end
    return r;
  endfunction

  // Polarity is folded in ahead of the synchronizer so everything downstream
  // works on active-high values.
  logic [SOURCES-1:0] x_act;
  assign x_act = src_async ^ ~POLARITY;

  genvar gi;
  generate
    for (gi = 0; gi < SOURCES; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_p;
      logic                   v;
      logic                   s_q;
      logic [FILTER_BITS-1:0] cnt_q;
      logic                   rise_q;
      logic                   glitch_q;
      filt_t                  nxt;

      // ---- stage: synchronizer chain, bit 0 is the metastable capture flop
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          sync_p <= '0;
        end else begin
          sync_p <= {sync_p[SYNC_STAGES-2:0], x_act[gi]};
        end
      end

      assign v = sync_p[SYNC_STAGES-1];

      always_comb begin
        nxt = filt_step(v, s_q, bypass[gi], cnt_q);
      end

      // ---- stage: filter, edge detect and sticky glitch flag
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          s_q      <= 1'b0;
          cnt_q    <= '0;
          rise_q   <= 1'b0;
          glitch_q <= 1'b0;
        end else begin
          s_q      <= nxt.s;
          cnt_q    <= nxt.cnt;
          // Registered with s so the pulse covers the first cycle src is high.
          rise_q   <= nxt.s & ~s_q;
          // A set on the same edge as a clear wins.
          glitch_q <= nxt.glitch_set | (glitch_q & ~glitch_clr[gi]);
        end
      end

      assign src[gi]      = s_q;
      assign src_rise[gi] = rise_q;
      assign glitch[gi]   = glitch_q;
    end
  endgenerate

endmodule

// File: tb/tb_plic_src_conditioner.sv
// -----------------------------------------------------------------------------
// tb_plic_src_conditioner
//
// Directed bench for plic_src_conditioner with default parameters except that
// line 3 is active-low. Inputs are driven 1 time unit after a rising edge and
// outputs are sampled at the same point, so "after edge k+n" below means the
// value visible once n further rising edges have occurred.
// -----------------------------------------------------------------------------
module tb_plic_src_conditioner;

  localparam int unsigned SOURCES = 5;

  logic               PCLK;
  logic               PRESETn;
  logic [SOURCES-1:0] src_async;
  logic [SOURCES-1:0] bypass;
  logic [SOURCES-1:0] glitch_clr;
  logic [SOURCES-1:0] src;
  logic [SOURCES-1:0] src_rise;
  logic [SOURCES-1:0] glitch;

  int checks;
  int errors;

  plic_src_conditioner #(
    .SOURCES      (SOURCES),
    .SYNC_STAGES  (2),
    .FILTER_BITS  (4),
    .FILTER_CYCLES(4),
    .POLARITY     (5'b10111)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .src_async (src_async),
    .bypass    (bypass),
    .glitch_clr(glitch_clr),
    .src       (src),
    .src_rise  (src_rise),
    .glitch    (glitch)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    PRESETn    = 1'b0;
    src_async  = 5'b11111;
    bypass     = 5'b01000;
    glitch_clr = 5'b00000;

    // Reset held with every raw line high: nothing may come out.
    tick(3);
    chk("rst_src",    32'(src),      32'h0);
    chk("rst_rise",   32'(src_rise), 32'h0);
    chk("rst_glitch", 32'(glitch),   32'h0);

    // All lines inactive (line 3 is active-low, so its idle level is 1).
    src_async = 5'b01000;
    PRESETn   = 1'b1;
    tick(8);
    chk("idle_src",    32'(src),    32'h0);
    chk("idle_glitch", 32'(glitch), 32'h0);

    // Line 0 rises after edge k: src at k+6, pulse only in that first cycle.
    src_async[0] = 1'b1;
    tick(5);
    chk("l0_src_k5",  32'(src[0]),      32'h0);
    tick(1);
    chk("l0_src_k6",  32'(src[0]),      32'h1);
    chk("l0_rise_k6", 32'(src_rise[0]), 32'h1);
    tick(1);
    chk("l0_src_k7",  32'(src[0]),      32'h1);
    chk("l0_rise_k7", 32'(src_rise[0]), 32'h0);

    // Line 1, 3-cycle pulse: rejected, glitch set at k+6 when v returns low.
    src_async[1] = 1'b1;
    tick(3);
    src_async[1] = 1'b0;
    tick(2);
    chk("l1_glitch_k5", 32'(glitch[1]), 32'h0);
    tick(1);
    chk("l1_glitch_k6", 32'(glitch[1]), 32'h1);
    tick(4);
    chk("l1_src_short", 32'(src[1]),    32'h0);
    chk("l1_glitch_hold", 32'(glitch[1]), 32'h1);

    glitch_clr[1] = 1'b1;
    tick(1);
    glitch_clr[1] = 1'b0;
    chk("l1_glitch_clr", 32'(glitch[1]), 32'h0);

    // Line 1, 4-cycle pulse: accepted, src high for edges k+6..k+9.
    src_async[1] = 1'b1;
    tick(4);
    src_async[1] = 1'b0;
    tick(1);
    chk("l1_long_k5",   32'(src[1]),      32'h0);
    tick(1);
    chk("l1_long_k6",   32'(src[1]),      32'h1);
    chk("l1_rise_k6",   32'(src_rise[1]), 32'h1);
    tick(1);
    chk("l1_rise_k7",   32'(src_rise[1]), 32'h0);
    tick(2);
    chk("l1_long_k9",   32'(src[1]),      32'h1);
    tick(1);
    chk("l1_long_k10",  32'(src[1]),      32'h0);
    chk("l1_fall_rise", 32'(src_rise[1]), 32'h0);
    chk("l1_long_glitch", 32'(glitch[1]), 32'h0);

    // Line 2, 2-cycle pulse with clear sampled on the detecting edge k+5.
    src_async[2] = 1'b1;
    tick(2);
    src_async[2] = 1'b0;
    tick(2);
    chk("l2_glitch_k4", 32'(glitch[2]), 32'h0);
    glitch_clr[2] = 1'b1;
    tick(1);
    glitch_clr[2] = 1'b0;
    chk("l2_collide", 32'(glitch[2]), 32'h1);
    tick(1);
    chk("l2_hold", 32'(glitch[2]), 32'h1);

    // Line 3, active-low and bypassed: asserted after k shows at k+3.
    src_async[3] = 1'b0;
    tick(2);
    chk("l3_src_k2",  32'(src[3]),      32'h0);
    tick(1);
    chk("l3_src_k3",  32'(src[3]),      32'h1);
    chk("l3_rise_k3", 32'(src_rise[3]), 32'h1);
    src_async[3] = 1'b1;
    tick(4);
    chk("l3_idle", 32'(src[3]), 32'h0);
    // One-cycle active pulse passes straight through.
    src_async[3] = 1'b0;
    tick(1);
    src_async[3] = 1'b1;
    tick(2);
    chk("l3_pulse_k3", 32'(src[3]),    32'h1);
    tick(1);
    chk("l3_pulse_k4", 32'(src[3]),    32'h0);
    chk("l3_glitch",   32'(glitch[3]), 32'h0);

    // Line 4: reset at cnt = 2 clears everything without waiting for a clock.
    src_async[4] = 1'b1;
    tick(4);
    chk("l4_pre_rst", 32'(src[4]), 32'h0);
    PRESETn = 1'b0;
    #1;
    chk("async_rst_src",    32'(src),    32'h0);
    chk("async_rst_glitch", 32'(glitch), 32'h0);
    tick(2);
    PRESETn = 1'b1;
    // Input still active: normal 6-edge latency from the release point.
    tick(5);
    chk("l4_rel_k5",  32'(src[4]),      32'h0);
    tick(1);
    chk("l4_rel_k6",  32'(src[4]),      32'h1);
    chk("l4_rise_k6", 32'(src_rise[4]), 32'h1);
    chk("l0_rel_k6",  32'(src[0]),      32'h1);

    // Line 4 falling, bypass turned on at cnt = 2 and off again: no glitch.
    src_async[4] = 1'b0;
    tick(4);
    chk("l4_fall_k4", 32'(src[4]), 32'h1);
    bypass[4] = 1'b1;
    tick(1);
    chk("l4_byp_src", 32'(src[4]), 32'h0);
    bypass[4] = 1'b0;
    tick(3);
    chk("l4_byp_glitch", 32'(glitch[4]), 32'h0);
    chk("l4_byp_src2",   32'(src[4]),    32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
